// File: rtl/pipe_mux_reg_if.sv
// pipe_mux_reg_if: handshake and data bundle for pipe_mux_reg.
//   in_bus    NUM_IN*WIDTH  packed inputs, input i = in_bus[i*WIDTH +: WIDTH]
//   sel       SEL_W         input index offered with in_valid
//   in_valid / in_ready     upstream handshake
//   out_ready               downstream accepts the head entry
//   flush                   synchronous kill of all held entries
//   out_data / out_sel / out_err / out_valid   head entry
//   out_par                 head parity, present only with PIPE_MUX_PARITY_EN
// master: the side driving inputs and consuming outputs; slave: the stage.
interface pipe_mux_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    out_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_err;
  logic                    out_valid;
`ifdef PIPE_MUX_PARITY_EN
  logic                    out_par;
`endif

  modport master (
    output in_bus, sel, in_valid, out_ready, flush,
    input  in_ready, out_data, out_sel, out_err, out_valid
`ifdef PIPE_MUX_PARITY_EN
    , input out_par
`endif
  );

  modport slave (
    input  in_bus, sel, in_valid, out_ready, flush,
    output in_ready, out_data, out_sel, out_err, out_valid
`ifdef PIPE_MUX_PARITY_EN
    , output out_par
`endif
  );
endinterface

// File: rtl/pipe_mux_reg.sv
// pipe_mux_reg: N:1 select mux feeding a 2-entry registered skid stage
// (head + skid) with a full-throughput valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_mux_reg_if.slave (in_bus, sel, in_valid, in_ready, out_ready,
//          flush, out_data, out_sel, out_err, out_valid[, out_par])
// Optional feature macro: PIPE_MUX_PARITY_EN adds out_par = ^data of the head,
// computed at capture and carried through the skid entry.
// in_ready comes straight from a flop (it is the inverse of skid occupancy).
module pipe_mux_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic           clk,
  input logic           rst_n,
  pipe_mux_reg_if.slave bus
);

  // Encoding mirrors {skid_valid, out_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  state_e           state_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] head_data_q, skid_data_q;
  logic [SEL_W-1:0] head_sel_q,  skid_sel_q;
  logic             head_err_q,  skid_err_q;
`ifdef PIPE_MUX_PARITY_EN
  logic             head_par_q,  skid_par_q;
`endif

  logic [WIDTH-1:0] cap_data_d;
  logic             cap_err_d;
  logic             accept;
  logic             pop;
  logic             out_valid;

  // Out-of-range selects match no input and leave the data at zero.
  always_comb begin
    cap_data_d = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.sel == SEL_W'(i)) cap_data_d = bus.in_bus[i*WIDTH +: WIDTH];
    end
  end

  assign cap_err_d = ({1'b0, bus.sel} >= NUM_IN_L);
  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_sel_q  <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
`ifdef PIPE_MUX_PARITY_EN
      head_par_q  <= 1'b0;
      skid_par_q  <= 1'b0;
`endif
    end else if (bus.flush) begin
      // Same-cycle accept/pop are dropped.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      head_data_q <= '0;
      head_sel_q  <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
`ifdef PIPE_MUX_PARITY_EN
      head_par_q  <= 1'b0;
      skid_par_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            head_data_q <= cap_data_d;
            head_sel_q  <= bus.sel;
            head_err_q  <= cap_err_d;
`ifdef PIPE_MUX_PARITY_EN
            head_par_q  <= ^cap_data_d;
`endif
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_data_q <= cap_data_d;
            head_sel_q  <= bus.sel;
            head_err_q  <= cap_err_d;
`ifdef PIPE_MUX_PARITY_EN
            head_par_q  <= ^cap_data_d;
`endif
          end else if (accept) begin
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
            skid_data_q <= cap_data_d;
            skid_sel_q  <= bus.sel;
            skid_err_q  <= cap_err_d;
`ifdef PIPE_MUX_PARITY_EN
            skid_par_q  <= ^cap_data_d;
`endif
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
            head_data_q <= skid_data_q;
            head_sel_q  <= skid_sel_q;
            head_err_q  <= skid_err_q;
`ifdef PIPE_MUX_PARITY_EN
            head_par_q  <= skid_par_q;
`endif
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data_q;
  assign bus.out_sel   = head_sel_q;
  assign bus.out_err   = head_err_q;
`ifdef PIPE_MUX_PARITY_EN
  assign bus.out_par   = head_par_q;
`endif

endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb_pipe_mux_reg: drives a NUM_IN=4 and a NUM_IN=3 instance with the same
// stimulus; a queue model of each stage is checked every cycle, plus
// hand-computed literal expectations at key points.
module tb_pipe_mux_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] bus_v;
  logic [1:0]   sel_v;
  logic         iv, ordy, fl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_mux_reg_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) if4 ();
  pipe_mux_reg_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) if3 ();

  assign if4.in_bus    = bus_v;
  assign if4.sel       = sel_v;
  assign if4.in_valid  = iv;
  assign if4.out_ready = ordy;
  assign if4.flush     = fl;
  assign if3.in_bus    = bus_v[95:0];
  assign if3.sel       = sel_v;
  assign if3.in_valid  = iv;
  assign if3.out_ready = ordy;
  assign if3.flush     = fl;

  pipe_mux_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  pipe_mux_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
    logic        p;
  } ent_t;

  ent_t q4[$];
  ent_t q3[$];
  bit   z4, z3;   // head registers known to be zero (after reset/flush, before any load)

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t cap(input logic [127:0] b, input logic [1:0] s, input int ni);
    ent_t r;
    r.s = s;
    r.e = (int'(s) >= ni);
    r.d = r.e ? 32'h0 : 32'(b >> (32 * int'(s)));
    r.p = ^r.d;
    return r;
  endfunction

  // Model: FIFO of at most two entries; ready while fewer than two held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q4.delete(); q3.delete();
      z4 = 1'b1;   z3 = 1'b1;
    end else if (fl) begin
      q4.delete(); q3.delete();
      z4 = 1'b1;   z3 = 1'b1;
    end else begin
      bit acc4, pop4, acc3, pop3;
      acc4 = iv && (q4.size() < 2);
      pop4 = ordy && (q4.size() > 0);
      acc3 = iv && (q3.size() < 2);
      pop3 = ordy && (q3.size() > 0);
      if (pop4) void'(q4.pop_front());
      if (acc4) begin q4.push_back(cap(bus_v, sel_v, 4)); z4 = 1'b0; end
      if (pop3) void'(q3.pop_front());
      if (acc3) begin q3.push_back(cap(bus_v, sel_v, 3)); z3 = 1'b0; end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid4", 64'(if4.out_valid), 64'(q4.size() != 0));
    chk("ready4", 64'(if4.in_ready),  64'(q4.size() < 2));
    if (q4.size() != 0) begin
      chk("data4", 64'(if4.out_data), 64'(q4[0].d));
      chk("sel4",  64'(if4.out_sel),  64'(q4[0].s));
      chk("err4",  64'(if4.out_err),  64'(q4[0].e));
`ifdef PIPE_MUX_PARITY_EN
      chk("par4",  64'(if4.out_par),  64'(q4[0].p));
`endif
    end else if (z4) begin
      chk("zero4", 64'({if4.out_data, if4.out_sel, if4.out_err}), 64'h0);
    end
    chk("valid3", 64'(if3.out_valid), 64'(q3.size() != 0));
    chk("ready3", 64'(if3.in_ready),  64'(q3.size() < 2));
    if (q3.size() != 0) begin
      chk("data3", 64'(if3.out_data), 64'(q3[0].d));
      chk("sel3",  64'(if3.out_sel),  64'(q3[0].s));
      chk("err3",  64'(if3.out_err),  64'(q3[0].e));
`ifdef PIPE_MUX_PARITY_EN
      chk("par3",  64'(if3.out_par),  64'(q3[0].p));
`endif
    end else if (z3) begin
      chk("zero3", 64'({if3.out_data, if3.out_sel, if3.out_err}), 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; iv = 1'b1; sel_v = 2'd0; ordy = 1'b1; fl = 1'b0;
    bus_v = {32'h44, 32'h33, 32'h22, 32'h11};

    // Reset with in_valid high: nothing recorded.
    tick(); tick();
    chk("rst_valid", 64'(if4.out_valid), 64'h0);
    chk("rst_data",  64'(if4.out_data),  64'h0);
    chk("rst_ready", 64'(if4.in_ready),  64'h1);
    rst_n = 1'b1;
    tick();
    chk("first_valid", 64'(if4.out_valid), 64'h1);
    chk("first_data",  64'(if4.out_data),  64'h11);
    iv = 1'b0;
    tick();
    chk("drain_valid", 64'(if4.out_valid), 64'h0);

    // Select sel=2 then 0 back-to-back.
    iv = 1'b1; sel_v = 2'd2;
    tick();
    chk("sel2_data", 64'(if4.out_data), 64'h33);
    chk("sel2_sel",  64'(if4.out_sel),  64'h2);
    sel_v = 2'd0;
    tick();
    chk("sel0_data", 64'(if4.out_data), 64'h11);
    chk("sel0_sel",  64'(if4.out_sel),  64'h0);
    iv = 1'b0;
    tick();

    // Backpressure: A then B held, third beat refused.
    ordy = 1'b0; iv = 1'b1; sel_v = 2'd1;
    bus_v[63:32] = 32'hA;
    tick();
    chk("bp_a_data",  64'(if4.out_data), 64'hA);
    chk("bp_a_ready", 64'(if4.in_ready), 64'h1);
    bus_v[63:32] = 32'hB;
    tick();
    chk("bp_full_ready", 64'(if4.in_ready), 64'h0);
    chk("bp_full_data",  64'(if4.out_data), 64'hA);
    bus_v[63:32] = 32'hC;
    tick();
    chk("bp_hold_data", 64'(if4.out_data), 64'hA);
    iv = 1'b0; ordy = 1'b1;
    tick();
    chk("bp_b_data",  64'(if4.out_data), 64'hB);
    chk("bp_b_ready", 64'(if4.in_ready), 64'h1);
    tick();
    chk("bp_empty", 64'(if4.out_valid), 64'h0);

    // Bad select on the 3-input instance.
    bus_v = {32'h44, 32'h33, 32'h22, 32'h11};
    iv = 1'b1; sel_v = 2'd3;
    tick();
    chk("bad_data3", 64'(if3.out_data), 64'h0);
    chk("bad_err3",  64'(if3.out_err),  64'h1);
    chk("bad_sel3",  64'(if3.out_sel),  64'h3);
    chk("ok_data4",  64'(if4.out_data), 64'h44);
    sel_v = 2'd1;
    tick();
    chk("good_err3",  64'(if3.out_err),  64'h0);
    chk("good_data3", 64'(if3.out_data), 64'h22);
    iv = 1'b0;
    tick();

    // Flush in FULL with in_valid high.
    ordy = 1'b0; iv = 1'b1; sel_v = 2'd0;
    tick();
    sel_v = 2'd1;
    tick();
    fl = 1'b1; sel_v = 2'd2;
    tick();
    chk("fl_valid", 64'(if4.out_valid), 64'h0);
    chk("fl_ready", 64'(if4.in_ready),  64'h1);
    chk("fl_data",  64'(if4.out_data),  64'h0);
    fl = 1'b0; iv = 1'b0; ordy = 1'b1;
    tick();
    chk("fl_gone", 64'(if4.out_valid), 64'h0);
    // Flush in ONE with simultaneous accept and pop.
    iv = 1'b1; sel_v = 2'd3;
    tick();
    fl = 1'b1; sel_v = 2'd1;
    tick();
    chk("fl1_valid", 64'(if4.out_valid), 64'h0);
    fl = 1'b0; iv = 1'b0;
    tick();

    // Parity through head and skid.
    bus_v = {32'h0, 32'h0, 32'h3, 32'h7};
    ordy = 1'b0; iv = 1'b1; sel_v = 2'd0;
    tick();
    chk("par_data7", 64'(if4.out_data), 64'h7);
`ifdef PIPE_MUX_PARITY_EN
    chk("par_7", 64'(if4.out_par), 64'h1);
`endif
    sel_v = 2'd1;
    tick();
    iv = 1'b0; ordy = 1'b1;
    tick();
    chk("par_data3", 64'(if4.out_data), 64'h3);
`ifdef PIPE_MUX_PARITY_EN
    chk("par_3", 64'(if4.out_par), 64'h0);
`endif
    tick();

    // Asynchronous reset in the middle of a cycle with both entries held.
    ordy = 1'b0; iv = 1'b1; sel_v = 2'd0;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(if4.out_valid), 64'h0);
    chk("arst_ready", 64'(if4.in_ready),  64'h1);
    chk("arst_data",  64'(if4.out_data),  64'h0);
    tick();
    rst_n = 1'b1; iv = 1'b0; ordy = 1'b1;
    tick();

    // Patterned traffic with mixed stalls and occasional flush.
    for (int i = 0; i < 400; i++) begin
      iv    = (i % 3) != 0;
      ordy  = (i % 5) < 3;
      sel_v = 2'(i % 4);
      fl    = (i % 37) == 36;
      bus_v = {32'(i) ^ 32'hA5A50004, 32'(i * 3) ^ 32'h5A5A0003,
               32'(i * 7) ^ 32'h0F0F0002, 32'(i * 11) ^ 32'hF0F00001};
      tick();
    end
    iv = 1'b0; fl = 1'b0; ordy = 1'b1;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
